layer_cmd_seq: RTL and testbench
================================

Name: layer_cmd_seq

Overview:
Issuing end of the global-buffer control command interface. It holds a queue of layer descriptors written by the host. For each descriptor it drives the 32-bit computation command and the initial data/weight addresses toward the global-buffer controller, then waits for that controller's done pulse before issuing the next layer. It sits between the host/config port and the global-buffer controller, and reports per-layer and end-of-program completion.

Parameters:
AW, 32, address width of data/weight initial addresses
DEPTH, 8, descriptor queue depth (power of 2, >=2)
TO_W, 20, width of the per-layer watchdog counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
desc_valid  input  1  host descriptor valid
desc_ready  output  1  queue not full; push when desc_valid&desc_ready
desc_type  input  3  computation type: 0 DWC, 1 PWC, 2 CON, 3 FC, 4 PO
desc_chn  input  28  dw channel / pw kernel count
desc_daddr  input  AW  data initial address
desc_waddr  input  AW  weight initial address
start  input  1  one-cycle pulse: begin executing queued descriptors
abort  input  1  one-cycle pulse: stop, flush queue, return to IDLE
comp_cmd  output  32  [31] init pulse, [30:28] type, [27:0] channel count
data_init_addr  output  AW  current layer data address
weight_init_addr  output  AW  current layer weight address
done_in  input  1  layer-done pulse from global-buffer controller
busy  output  1  not in IDLE
layer_done  output  1  one-cycle pulse per completed layer
all_done  output  1  one-cycle pulse when queue drains after start
layer_idx  output  8  layers completed since start (wraps at 255->0)
err_timeout  output  1  sticky: watchdog expired
err_type  output  1  sticky: descriptor with type>4 skipped

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE. desc_ready=1 after reset.
- Queue: FIFO of {type,chn,daddr,waddr}. Push on desc_valid&desc_ready in any state except the abort cycle. A push and pop in the same cycle are both honoured. Count stays in 0..DEPTH.
- States: IDLE, FETCH, ISSUE, WAIT, FIN, ERR.
- IDLE: comp_cmd=0. On start: clear layer_idx and go to FETCH (start is ignored in all other states).
- FETCH:
  - Queue empty -> FIN.
  - Otherwise pop into current-layer registers. type>4 -> set err_type, stay in FETCH for the next entry. Else -> ISSUE.
- ISSUE (exactly 1 cycle): comp_cmd={1'b1,type,chn}; addresses valid. Then WAIT.
- WAIT:
  - comp_cmd={1'b0,type,chn}; addresses held stable.
  - done_in is sampled only here. A done_in seen in ISSUE or FETCH is ignored.
  - On done_in: pulse layer_done, increment layer_idx, go to FETCH. First layer issue to second layer issue is therefore ≥3 cycles.
  - Watchdog: counts cycles in WAIT, cleared on ISSUE. Reaching all-ones (2^TO_W-1) -> set err_timeout, go to ERR.
- FIN: pulse all_done one cycle, comp_cmd=0 -> IDLE.
- ERR: comp_cmd=0, busy=1. Leaves only on abort.
- abort (any state): next state IDLE, queue flushed, comp_cmd=0. Clears err_timeout/err_type. Has priority over done_in and start in the same cycle. A push in the abort cycle is dropped.
- done_in and watchdog expiry in the same cycle: done_in wins (no error).
- Reset asserted mid-layer: immediate return to reset values; the downstream controller is expected to be reset by the same rst_n.
- Addresses output 0 in IDLE/FIN, register values otherwise.

Decomposition:
- Shared package mbn_pkg:
  - comp_type_e enum (DWC=3'h0, PWC=3'h1, CON=3'h2, FC=3'h3, PO=3'h4).
  - comp_cmd bit positions (INIT_BIT=31, TYPE_MSB/LSB=30/28, CHN_W=28).
  - packed layer_desc_t struct.
  - seq state enum.
- One sub-module, layer_desc_fifo: parameterised synchronous FIFO with full/empty, flush input and simultaneous push/pop.

Test Plan:
- Push 2 descs (DWC chn=32 daddr=0x100; PWC chn=64 daddr=0x200), start; done_in 10 cycles after each ISSUE -> comp_cmd=0x80000020 for 1 cycle then 0x00000020; then 0x90000040/0x10000040. Two layer_done pulses, layer_idx=2, all_done once, busy returns 0.
- start with empty queue -> FETCH->FIN; all_done pulses 2 cycles after start, comp_cmd never nonzero.
- Push type=5 then valid FC chn=10 -> err_type=1, only 0xB000000A issued, layer_idx=1.
- Withhold done_in with TO_W=4 -> err_timeout set 15 cycles into WAIT, state ERR. abort -> IDLE, errors cleared, queue empty.
- Fill DEPTH=8 -> desc_ready=0, 9th push dropped. Push during execution with simultaneous pop -> count unchanged, order preserved.
- done_in pulse during ISSUE cycle -> ignored, layer still waits. done_in coincident with abort -> no layer_done, IDLE.

Source files
------------

// File: rtl/mbn_pkg.sv
// Shared types for the layer command path: computation types, command word layout,
// stored descriptor format and sequencer states.
package mbn_pkg;

    typedef enum logic [2:0] {
        DWC = 3'h0,
        PWC = 3'h1,
        CON = 3'h2,
        FC  = 3'h3,
        PO  = 3'h4
    } comp_type_e;

    localparam int INIT_BIT = 31;
    localparam int TYPE_MSB = 30;
    localparam int TYPE_LSB = 28;
    localparam int CHN_W    = 28;
    // Address width of a stored descriptor; the sequencer's AW must match it.
    localparam int ADDR_W   = 32;

    // Type is kept raw (not comp_type_e) so out-of-range host values survive to be flagged.
    typedef struct packed {
        logic [2:0]        typ;
        logic [CHN_W-1:0]  chn;
        logic [ADDR_W-1:0] daddr;
        logic [ADDR_W-1:0] waddr;
    } layer_desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_FIN,
        S_ERR
    } seq_state_e;

endpackage

// File: rtl/layer_cmd_seq_if.sv
// Host-side descriptor push port of the layer command sequencer (valid/ready handshake).
interface layer_cmd_seq_if
    import mbn_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic             desc_valid;
    logic             desc_ready;
    logic [2:0]       desc_type;
    logic [CHN_W-1:0] desc_chn;
    logic [AW-1:0]    desc_daddr;
    logic [AW-1:0]    desc_waddr;

    modport master (
        output desc_valid, desc_type, desc_chn, desc_daddr, desc_waddr,
        input  desc_ready
    );

    modport slave (
        input  desc_valid, desc_type, desc_chn, desc_daddr, desc_waddr,
        output desc_ready
    );
endinterface

// File: rtl/layer_desc_fifo.sv
// Synchronous descriptor FIFO with flush; push and pop in one cycle are both honoured.
module layer_desc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/layer_cmd_seq.sv
// Layer command sequencer: drains host-queued layer descriptors into the global-buffer
// controller one command at a time, waiting for its done pulse between layers.
module layer_cmd_seq
    import mbn_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int DEPTH = 8,
    parameter int TO_W  = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    layer_cmd_seq_if.slave desc,
    input  logic           start,
    input  logic           abort,
    output logic [31:0]    comp_cmd,
    output logic [AW-1:0]  data_init_addr,
    output logic [AW-1:0]  weight_init_addr,
    input  logic           done_in,
    output logic           busy,
    output logic           layer_done,
    output logic           all_done,
    output logic [7:0]     layer_idx,
    output logic           err_timeout,
    output logic           err_type
);
    localparam logic [TO_W-1:0] WD_MAX = '1;

    seq_state_e      state, state_nx;
    layer_desc_t     din, head, cur;
    logic            full, empty, push, pop;
    logic            head_bad, fin_layer, wd_expire;
    logic [TO_W-1:0] wd, wd_inc;

    assign desc.desc_ready = ~full;
    assign push      = desc.desc_valid & ~full & ~abort;
    assign din       = '{typ: desc.desc_type, chn: desc.desc_chn,
                         daddr: desc.desc_daddr, waddr: desc.desc_waddr};
    assign head_bad  = (head.typ > 3'(PO));
    assign wd_inc    = wd + TO_W'(1);
    assign wd_expire = (state == S_WAIT) & ~done_in & (wd_inc == WD_MAX);
    assign fin_layer = (state == S_WAIT) & done_in & ~abort;

    layer_desc_fifo #(
        .WIDTH ($bits(layer_desc_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push),
        .wdata (din),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx         = state;
        pop              = 1'b0;
        comp_cmd         = '0;
        data_init_addr   = '0;
        weight_init_addr = '0;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: begin
                if (empty) begin
                    state_nx = S_FIN;
                end else begin
                    pop = 1'b1;
                    if (!head_bad) state_nx = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (done_in)        state_nx = S_FETCH;
                else if (wd_expire) state_nx = S_ERR;
            end
            S_FIN:   state_nx = S_IDLE;
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
            pop      = 1'b0;
        end

        if (state == S_ISSUE || state == S_WAIT) begin
            comp_cmd[INIT_BIT]          = (state == S_ISSUE);
            comp_cmd[TYPE_MSB:TYPE_LSB] = cur.typ;
            comp_cmd[CHN_W-1:0]         = cur.chn;
        end
        if (state != S_IDLE && state != S_FIN) begin
            data_init_addr   = cur.daddr;
            weight_init_addr = cur.waddr;
        end
    end

    assign busy     = (state != S_IDLE);
    assign all_done = (state == S_FIN);

    // Abort outranks every other event, including a done_in landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur         <= '0;
            wd          <= '0;
            layer_done  <= 1'b0;
            layer_idx   <= '0;
            err_timeout <= 1'b0;
            err_type    <= 1'b0;
        end else begin
            state      <= state_nx;
            layer_done <= fin_layer;
            if (pop) cur <= head;
            if (state == S_ISSUE)     wd <= '0;
            else if (state == S_WAIT) wd <= wd_inc;
            if (state == S_IDLE && start && !abort) layer_idx <= '0;
            else if (fin_layer)                     layer_idx <= layer_idx + 8'd1;
            if (abort) begin
                err_timeout <= 1'b0;
                err_type    <= 1'b0;
            end else begin
                if (pop && head_bad) err_type    <= 1'b1;
                if (wd_expire)       err_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_layer_cmd_seq.sv
// Self-checking bench for layer_cmd_seq: directed sequences, a table of single-layer
// programs and a randomized run checked against a descriptor-queue scoreboard.
module tb_layer_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        done_in = 1'b0;
    logic [31:0] comp_cmd, data_init_addr, weight_init_addr;
    logic        busy, layer_done, all_done, err_timeout, err_type;
    logic [7:0]  layer_idx;

    layer_cmd_seq_if #(.AW(32)) dif ();

    layer_cmd_seq #(.AW(32), .DEPTH(8), .TO_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .desc             (dif),
        .start            (start),
        .abort            (abort),
        .comp_cmd         (comp_cmd),
        .data_init_addr   (data_init_addr),
        .weight_init_addr (weight_init_addr),
        .done_in          (done_in),
        .busy             (busy),
        .layer_done       (layer_done),
        .all_done         (all_done),
        .layer_idx        (layer_idx),
        .err_timeout      (err_timeout),
        .err_type         (err_type)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  typ;
        logic [27:0] chn;
        logic [31:0] daddr;
        logic [31:0] waddr;
    } desc_t;

    typedef struct {
        logic [2:0]  typ;
        logic [27:0] chn;
        logic [31:0] daddr;
        logic [31:0] waddr;
        int          dly;
        logic [31:0] exp_cmd;
        logic [7:0]  exp_idx;
        logic        exp_errt;
    } vec_t;

    vec_t  vt [6];
    desc_t sb [$];
    desc_t nd, ex;

    int nvec = 0, nerr = 0;
    int ad_cnt = 0, ld_cnt = 0, nz_cnt = 0, is_cnt = 0;
    int ad0, ld0, nz0, is0, cnt, dly, extra, issued;
    bit waiting, fetch_next, drove_done, acc, fin_seen;

    always @(negedge clk) begin
        if (all_done)    ad_cnt <= ad_cnt + 1;
        if (layer_done)  ld_cnt <= ld_cnt + 1;
        if (comp_cmd != 0) nz_cnt <= nz_cnt + 1;
        if (comp_cmd[31]) is_cnt <= is_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] t, input logic [27:0] c, input logic [31:0] d, input logic [31:0] w);
        dif.desc_valid = 1'b1;
        dif.desc_type  = t;
        dif.desc_chn   = c;
        dif.desc_daddr = d;
        dif.desc_waddr = w;
        tick();
        dif.desc_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Waits (bounded) for the init pulse, checks issue and wait words, answers after dly cycles.
    task automatic do_layer(input string tag, input logic [31:0] cmd, input logic [31:0] d,
                            input logic [31:0] w, input int dly_c);
        for (int k = 0; k < 20 && !comp_cmd[31]; k++) tick();
        check({tag, ".issue"}, comp_cmd, cmd);
        check({tag, ".daddr"}, data_init_addr, d);
        check({tag, ".waddr"}, weight_init_addr, w);
        tick();
        check({tag, ".wait"}, comp_cmd, cmd & 32'h7FFF_FFFF);
        repeat (dly_c - 1) tick();
        check({tag, ".held"}, data_init_addr, d);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check({tag, ".layer_done"}, layer_done, 1);
    endtask

    function automatic desc_t rand_desc();
        desc_t r;
        r.typ   = 3'($urandom_range(0, 4));
        r.chn   = 28'($urandom_range(1, 32'h0FFF_FFFF));
        r.daddr = $urandom;
        r.waddr = $urandom;
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vt[0] = '{3'd1, 28'd3,         32'h0000_0010, 32'h0000_0020, 1,  32'h9000_0003, 8'd1, 1'b0};
        vt[1] = '{3'd2, 28'h0FF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 14, 32'hA0FF_FFFF, 8'd1, 1'b0};
        vt[2] = '{3'd4, 28'd1,         32'h1234_5678, 32'h8765_4321, 15, 32'hC000_0001, 8'd1, 1'b0};
        vt[3] = '{3'd3, 28'd10,        32'h0000_0300, 32'h0000_3000, 2,  32'hB000_000A, 8'd1, 1'b0};
        vt[4] = '{3'd6, 28'd9,         32'h0000_0400, 32'h0000_4000, 1,  32'h0000_0000, 8'd0, 1'b1};
        vt[5] = '{3'd0, 28'h20,        32'h0000_0500, 32'h0000_5000, 10, 32'h8000_0020, 8'd1, 1'b0};

        dif.desc_valid = 1'b0;
        dif.desc_type  = '0;
        dif.desc_chn   = '0;
        dif.desc_daddr = '0;
        dif.desc_waddr = '0;
        repeat (3) tick();
        check("rst.comp_cmd", comp_cmd, 0);
        check("rst.ready", dif.desc_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.idx", layer_idx, 0);
        check("rst.errs", {err_timeout, err_type, layer_done, all_done}, 0);
        check("rst.addr", data_init_addr | weight_init_addr, 0);
        rst_n = 1'b1;
        tick();

        // Two-layer program
        push(3'd0, 28'd32, 32'h100, 32'h1000);
        push(3'd1, 28'd64, 32'h200, 32'h2000);
        ad0 = ad_cnt; ld0 = ld_cnt;
        pulse_start();
        do_layer("t1.l0", 32'h8000_0020, 32'h100, 32'h1000, 10);
        do_layer("t1.l1", 32'h9000_0040, 32'h200, 32'h2000, 10);
        check("t1.idx", layer_idx, 2);
        tick();
        check("t1.all_done", all_done, 1);
        check("t1.fin_addr", data_init_addr, 0);
        tick();
        check("t1.busy", busy, 0);
        check("t1.ad_cnt", ad_cnt - ad0, 1);
        check("t1.ld_cnt", ld_cnt - ld0, 2);
        check("t1.idx_hold", layer_idx, 2);

        // Start on an empty queue
        ad0 = ad_cnt; nz0 = nz_cnt;
        pulse_start();
        check("t2.busy", busy, 1);
        check("t2.idx_clr", layer_idx, 0);
        tick();
        check("t2.all_done", all_done, 1);
        tick();
        check("t2.idle", busy, 0);
        check("t2.no_cmd", nz_cnt - nz0, 0);
        check("t2.ad_cnt", ad_cnt - ad0, 1);

        // Invalid type skipped, following FC issued
        push(3'd5, 28'd7, 32'hDEAD, 32'hBEEF);
        push(3'd3, 28'd10, 32'h300, 32'h3000);
        is0 = is_cnt;
        pulse_start();
        do_layer("t3", 32'hB000_000A, 32'h300, 32'h3000, 3);
        check("t3.err_type", err_type, 1);
        check("t3.idx", layer_idx, 1);
        repeat (2) tick();
        check("t3.issues", is_cnt - is0, 1);
        check("t3.busy", busy, 0);
        pulse_abort();
        check("t3.err_clr", err_type, 0);

        // Watchdog expiry, ERR, abort with a queued descriptor
        push(3'd0, 28'd1, 32'h40, 32'h50);
        pulse_start();
        for (int k = 0; k < 20 && !comp_cmd[31]; k++) tick();
        check("t4.issue", comp_cmd, 32'h8000_0001);
        repeat (15) tick();
        check("t4.pre_err", err_timeout, 0);
        check("t4.wait_cmd", comp_cmd, 32'h0000_0001);
        tick();
        check("t4.err", err_timeout, 1);
        check("t4.err_cmd", comp_cmd, 0);
        check("t4.err_busy", busy, 1);
        check("t4.err_addr", data_init_addr, 32'h40);
        push(3'd1, 28'd2, 32'h60, 32'h70);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        repeat (2) tick();
        check("t4.stuck", {busy, err_timeout}, 2'b11);
        pulse_abort();
        check("t4.abort_busy", busy, 0);
        check("t4.abort_err", {err_timeout, err_type}, 0);
        is0 = is_cnt;
        pulse_start();
        tick();
        check("t4.flushed", all_done, 1);
        tick();
        check("t4.no_issue", is_cnt - is0, 0);

        // done_in during ISSUE ignored; done_in with abort gives no layer_done
        push(3'd0, 28'd5, 32'h80, 32'h90);
        pulse_start();
        for (int k = 0; k < 20 && !comp_cmd[31]; k++) tick();
        check("t6.issue", comp_cmd, 32'h8000_0005);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check("t6.still_wait", comp_cmd, 32'h0000_0005);
        check("t6.no_ld", layer_done, 0);
        repeat (3) tick();
        check("t6.wait2", comp_cmd, 32'h0000_0005);
        done_in = 1'b1;
        abort   = 1'b1;
        dif.desc_valid = 1'b1;
        dif.desc_type  = 3'd1;
        dif.desc_chn   = 28'd77;
        tick();
        done_in = 1'b0;
        abort   = 1'b0;
        dif.desc_valid = 1'b0;
        check("t6.abort_ld", layer_done, 0);
        check("t6.abort_idle", {busy, comp_cmd != 0}, 0);
        check("t6.idx", layer_idx, 0);
        pulse_start();
        tick();
        check("t6.push_dropped", all_done, 1);
        tick();

        // Table of single-layer programs
        for (int i = 0; i < 6; i++) begin
            push(vt[i].typ, vt[i].chn, vt[i].daddr, vt[i].waddr);
            ad0 = ad_cnt; is0 = is_cnt;
            pulse_start();
            if (vt[i].exp_cmd != 0)
                do_layer($sformatf("v%0d", i), vt[i].exp_cmd, vt[i].daddr, vt[i].waddr, vt[i].dly);
            for (int k = 0; k < 10 && !all_done; k++) tick();
            check($sformatf("v%0d.all_done", i), all_done, 1);
            check($sformatf("v%0d.idx", i), layer_idx, vt[i].exp_idx);
            check($sformatf("v%0d.err_type", i), err_type, vt[i].exp_errt);
            check($sformatf("v%0d.err_to", i), err_timeout, 0);
            tick();
            check($sformatf("v%0d.issues", i), is_cnt - is0, (vt[i].exp_cmd != 0) ? 1 : 0);
            check($sformatf("v%0d.busy", i), busy, 0);
            pulse_abort();
        end

        // Randomized program against a descriptor-queue scoreboard
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            nd = rand_desc();
            push(nd.typ, nd.chn, nd.daddr, nd.waddr);
            sb.push_back(nd);
        end
        check("rnd.full", dif.desc_ready, 0);
        nd = rand_desc();
        push(nd.typ, nd.chn, nd.daddr, nd.waddr);
        check("rnd.full_drop", dif.desc_ready, 0);
        ad0 = ad_cnt; ld0 = ld_cnt;
        waiting = 0; fetch_next = 0; fin_seen = 0;
        cnt = 0; dly = 0; extra = 12; issued = 0;
        pulse_start();
        for (int cyc = 0; cyc < 3000 && !fin_seen; cyc++) begin
            if ((waiting || (fetch_next && sb.size() > 0)) && extra > 0 && $urandom_range(0, 2) == 0) begin
                nd = rand_desc();
                dif.desc_valid = 1'b1;
                dif.desc_type  = nd.typ;
                dif.desc_chn   = nd.chn;
                dif.desc_daddr = nd.daddr;
                dif.desc_waddr = nd.waddr;
            end
            drove_done = waiting && (cnt == dly);
            done_in    = drove_done;
            acc        = dif.desc_valid && dif.desc_ready;
            tick();
            dif.desc_valid = 1'b0;
            done_in        = 1'b0;
            if (acc) begin
                sb.push_back(nd);
                extra--;
            end
            fetch_next = drove_done;
            if (drove_done) waiting = 0;
            else if (waiting) cnt++;
            check("rnd.layer_done", layer_done, fetch_next);
            if (comp_cmd[31]) begin
                if (sb.size() == 0) begin
                    check("rnd.extra_issue", comp_cmd, 0);
                end else begin
                    ex = sb.pop_front();
                    check("rnd.cmd", comp_cmd, {1'b1, ex.typ, ex.chn});
                    check("rnd.daddr", data_init_addr, ex.daddr);
                    check("rnd.waddr", weight_init_addr, ex.waddr);
                end
                issued++;
                waiting = 1;
                cnt     = 0;
                dly     = $urandom_range(1, 12);
            end
            if (all_done) fin_seen = 1;
            check("rnd.ready", dif.desc_ready, sb.size() < 8);
        end
        check("rnd.finished", fin_seen, 1);
        check("rnd.sb_left", sb.size(), 0);
        check("rnd.idx", layer_idx, 8'(issued));
        check("rnd.ld_cnt", ld_cnt - ld0, issued);
        tick();
        check("rnd.ad_cnt", ad_cnt - ad0, 1);
        check("rnd.busy", busy, 0);
        check("rnd.err", {err_timeout, err_type}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
